// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Round-robin select generator and sampler for a 4:1 mux stage.
//               Holds each enabled channel for DWELL cycles, captures the mux
//               output D on the last dwell cycle and pulses VALID once per
//               completed sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       HOLD,
  input  logic [3:0] MASK,
  input  logic       D,
  output logic       S1,
  output logic       S0,
  output logic [3:0] SAMPLE,
  output logic       VALID,
  output logic       BUSY
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    sel_q,   sel_d;
  logic [3:0]    sample_q, sample_d;
  logic          valid_q, valid_d;

  // Lowest-index enabled channel (0 when the mask is empty; caller guards).
  function automatic logic [1:0] lowest_sel(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Highest-index enabled channel; marks the end of a sweep.
  function automatic logic [1:0] highest_sel(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next enabled channel strictly above cur, wrapping; a lone channel maps to itself.
  function automatic logic [1:0] next_sel(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = cur + 2'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Next-state, dwell counter, select and capture logic (EN > HOLD > count).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN && (MASK != 4'b0000)) begin
          sel_d   = lowest_sel(MASK);
          cnt_d   = '0;
          state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (!EN) begin
          // Abort: no capture, select is left where it was.
          state_d = ST_IDLE;
        end else if (HOLD) begin
          // Frozen; a pending capture waits here with cnt at its last value.
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          sample_d[sel_q] = D;
          cnt_d           = '0;
          if (MASK == 4'b0000) begin
            state_d = ST_IDLE;
          end else begin
            sel_d   = next_sel(MASK, sel_q);
            valid_d = (sel_q == highest_sel(MASK));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      sample_q <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign S1     = sel_q[1];
  assign S0     = sel_q[0];
  assign SAMPLE = sample_q;
  assign VALID  = valid_q;
  assign BUSY   = (state_q == ST_DWELL);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench; three instances (DWELL = 4, 2, 1) share
//               stimulus and are compared against a channel-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic [3:0] in_vec = 4'b0000;

  logic [2:0] s1_w, s0_w, valid_w, busy_w, d_w;
  logic [3:0] samp_w [3];

  int n_total = 0;
  int n_bad   = 0;

  // Model state per instance
  int         dw     [3] = '{4, 2, 1};
  bit         m_act  [3];
  int         m_ch   [3];
  int         m_el   [3];
  logic [3:0] m_samp [3];
  bit         m_val  [3];

  always #5 clk = ~clk;

  // The mux itself: D follows the selected input combinationally.
  assign d_w[0] = in_vec[{s1_w[0], s0_w[0]}];
  assign d_w[1] = in_vec[{s1_w[1], s0_w[1]}];
  assign d_w[2] = in_vec[{s1_w[2], s0_w[2]}];

  mux_scan_ctrl #(.DWELL(4), .CW(8)) u_dut4 (
    .clk(clk), .rst(rst), .EN(en), .HOLD(hold), .MASK(mask), .D(d_w[0]),
    .S1(s1_w[0]), .S0(s0_w[0]), .SAMPLE(samp_w[0]), .VALID(valid_w[0]), .BUSY(busy_w[0]));

  mux_scan_ctrl #(.DWELL(2), .CW(8)) u_dut2 (
    .clk(clk), .rst(rst), .EN(en), .HOLD(hold), .MASK(mask), .D(d_w[1]),
    .S1(s1_w[1]), .S0(s0_w[1]), .SAMPLE(samp_w[1]), .VALID(valid_w[1]), .BUSY(busy_w[1]));

  mux_scan_ctrl #(.DWELL(1), .CW(8)) u_dut1 (
    .clk(clk), .rst(rst), .EN(en), .HOLD(hold), .MASK(mask), .D(d_w[2]),
    .S1(s1_w[2]), .S0(s0_w[2]), .SAMPLE(samp_w[2]), .VALID(valid_w[2]), .BUSY(busy_w[2]));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int low_ch(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int high_ch(input logic [3:0] m);
    for (int i = 3; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_ch(input logic [3:0] m, input int c);
    for (int j = c + 1; j < 4; j++) if (m[j]) return j;
    return low_ch(m);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_act[k] = 0; m_ch[k] = 0; m_el[k] = 0; m_samp[k] = 4'b0000; m_val[k] = 0;
    end
  endtask

  // One clock edge of the scan as described at channel level.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0;
      if (!m_act[k]) begin
        if (en && mask != 4'b0000) begin
          m_act[k] = 1; m_ch[k] = low_ch(mask); m_el[k] = 0;
        end
      end else if (!en) begin
        m_act[k] = 0;
      end else if (hold) begin
        // nothing moves
      end else if (m_el[k] + 1 < dw[k]) begin
        m_el[k]++;
      end else begin
        m_samp[k][m_ch[k]] = in_vec[m_ch[k]];
        m_el[k] = 0;
        if (mask == 4'b0000) begin
          m_act[k] = 0;
        end else begin
          m_val[k] = (m_ch[k] == high_ch(mask));
          m_ch[k]  = next_ch(mask, m_ch[k]);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("sel[%0d]", k),    {30'd0, s1_w[k], s0_w[k]}, m_ch[k]);
      check_val($sformatf("sample[%0d]", k), {28'd0, samp_w[k]}, {28'd0, m_samp[k]});
      check_val($sformatf("valid[%0d]", k),  {31'd0, valid_w[k]}, {31'd0, m_val[k]});
      check_val($sformatf("busy[%0d]", k),   {31'd0, busy_w[k]}, {31'd0, m_act[k]});
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      @(negedge clk);
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    for (int k = 0; k < 3; k++)
      check_val($sformatf("rst_async[%0d]", k),
                {24'd0, s1_w[k], s0_w[k], samp_w[k], valid_w[k], busy_w[k]}, 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    @(negedge clk);
    compare_all();
    for (int k = 0; k < 3; k++)
      check_val($sformatf("reset[%0d]", k),
                {24'd0, s1_w[k], s0_w[k], samp_w[k], valid_w[k], busy_w[k]}, 32'd0);
    rst = 1'b0;

    // Full sweep: inputs I3..I0 = 1,1,0,1
    en = 1'b1; mask = 4'b1111; in_vec = 4'b1101;
    tick(17);
    check_val("sweep_sample", {28'd0, samp_w[0]}, 32'h0000000D);
    check_val("sweep_valid", {31'd0, valid_w[0]}, 32'd1);
    tick(16);

    // Sparse mask
    mask = 4'b1010; in_vec = 4'b0010;
    tick(8);
    in_vec = 4'b1000;
    tick(8);

    // Hold at cnt=2 on the DWELL=4 instance
    mask = 4'b1111; in_vec = 4'b0110;
    guard = 0;
    while (!(m_act[0] && m_el[0] == 2) && guard < 50) begin
      tick(1);
      guard++;
    end
    check_val("hold_reach", {31'd0, guard < 50}, 32'd1);
    hold = 1'b1;
    tick(5);
    hold = 1'b0;
    tick(3);

    // Abort with EN low, then mid-dwell async reset
    en = 1'b0;
    tick(2);
    check_val("abort_busy", {31'd0, busy_w[0]}, 32'd0);
    en = 1'b1;
    tick(3);
    pulse_reset();
    tick(2);

    // Empty mask with EN high, then mask dropped to 0 mid-dwell
    mask = 4'b0000;
    tick(6);
    check_val("empty_idle", {29'd0, busy_w}, 32'd0);
    mask = 4'b0100;
    tick(2);
    mask = 4'b0000;
    tick(6);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      en     = ($urandom_range(0, 19) != 0);
      hold   = ($urandom_range(0, 6) == 0);
      in_vec = 4'($urandom);
      if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 149) == 0) pulse_reset();
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
